// File: rtl/logic_unit_pkg.sv
//------------------------------------------------------------------------------
// logic_unit_pkg : opcodes, legality check and popcount helper for logic_unit_pipe
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package logic_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOT_A         = 4'd0,
        OP_NOT_B         = 4'd1,
        OP_AND           = 4'd2,
        OP_OR            = 4'd3,
        OP_NAND          = 4'd4,
        OP_NOR           = 4'd5,
        OP_NOTA_AND_NOTB = 4'd6,
        OP_NOTA_OR_NOTB  = 4'd7,
        OP_XOR           = 4'd8,
        OP_XNOR          = 4'd9
    } op_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

    // Widest operand the popcount helper covers; callers zero-extend to this.
    localparam int POP_MAX_W = 256;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

    function automatic logic [15:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [15:0] cnt;
        cnt = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            cnt = cnt + 16'(v[i]);
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/logic_unit_core.sv
//------------------------------------------------------------------------------
// logic_unit_core : combinational WIDTH-bit bitwise logic unit (primary or dual form)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit DUAL_FORM = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    // The dual instance evaluates the De Morgan ops through their equivalent form.
    always_comb begin
        result  = '0;
        illegal = !is_legal(op);
        case (op)
            OP_NOT_A:         result = ~a;
            OP_NOT_B:         result = ~b;
            OP_AND:           result = a & b;
            OP_OR:            result = a | b;
            OP_NAND:          result = DUAL_FORM ? (~a | ~b) : ~(a & b);
            OP_NOR:           result = DUAL_FORM ? (~a & ~b) : ~(a | b);
            OP_NOTA_AND_NOTB: result = DUAL_FORM ? ~(a | b)  : (~a & ~b);
            OP_NOTA_OR_NOTB:  result = DUAL_FORM ? ~(a & b)  : (~a | ~b);
            OP_XOR:           result = a ^ b;
            OP_XNOR:          result = ~(a ^ b);
            default:          result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/logic_unit_pipe.sv
//------------------------------------------------------------------------------
// logic_unit_pipe : 2-stage valid/ready bitwise logic unit with ones count.
// Optional dual-form De Morgan check: define LOGIC_UNIT_DEMORGAN_CHECK_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef LOGIC_UNIT_DEMORGAN_CHECK_EN
   ,parameter int ERR_W = 8
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [3:0]                   op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             result,
    output logic [$clog2(WIDTH+1)-1:0]   ones,
    output logic                         illegal
`ifdef LOGIC_UNIT_DEMORGAN_CHECK_EN
   ,output logic                         err,
    output logic [ERR_W-1:0]             err_count
`endif
);

    localparam int ONES_W = $clog2(WIDTH+1);

    logic               r_v1;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;

    logic               r_v2;
    logic [WIDTH-1:0]   r_result;
    logic [ONES_W-1:0]  r_ones;
    logic               r_illegal;

    logic               w_load1;
    logic               w_load2;
    logic [WIDTH-1:0]   w_result;
    logic               w_illegal;
    logic [ONES_W-1:0]  w_ones;

    assign w_load2  = !r_v2 || out_ready;
    assign w_load1  = !r_v1 || w_load2;
    assign in_ready = w_load1;

    logic_unit_core #(
        .WIDTH     (WIDTH),
        .DUAL_FORM (1'b0)
    ) u_core (
        .a       (r_a),
        .b       (r_b),
        .op      (r_op),
        .result  (w_result),
        .illegal (w_illegal)
    );

    assign w_ones = ONES_W'(popcount(POP_MAX_W'(w_result)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
        end else if (w_load1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= op;
            end
        end
    end

    // Stage 2 payload only changes when a real beat moves in, so it stays stable under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_result  <= '0;
            r_ones    <= '0;
            r_illegal <= 1'b0;
        end else if (w_load2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_result  <= w_result;
                r_ones    <= w_ones;
                r_illegal <= w_illegal;
            end
        end
    end

    assign out_valid = r_v2;
    assign result    = r_result;
    assign ones      = r_ones;
    assign illegal   = r_illegal;

`ifdef LOGIC_UNIT_DEMORGAN_CHECK_EN
    logic [WIDTH-1:0]  w_dual_result;
    logic              w_dual_illegal;
    logic              w_mismatch;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_count;

    logic_unit_core #(
        .WIDTH     (WIDTH),
        .DUAL_FORM (1'b1)
    ) u_core_dual (
        .a       (r_a),
        .b       (r_b),
        .op      (r_op),
        .result  (w_dual_result),
        .illegal (w_dual_illegal)
    );

    assign w_mismatch = (w_result != w_dual_result) || (w_illegal != w_dual_illegal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_load2 && r_v1) begin
                r_err <= w_mismatch;
            end
            if (r_v2 && out_ready && r_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign err       = r_err && r_v2;
    assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
//------------------------------------------------------------------------------
// tb_logic_unit_pipe : directed + randomized bench for logic_unit_pipe (WIDTH=8)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] ones;
    logic       illegal;
`ifdef LOGIC_UNIT_DEMORGAN_CHECK_EN
    logic       err;
    logic [7:0] err_count;
`endif

    logic_unit_pipe #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ones      (ones),
        .illegal   (illegal)
`ifdef LOGIC_UNIT_DEMORGAN_CHECK_EN
       ,.err       (err),
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [3:0] n;
        logic       il;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour taken straight from the opcode table.
    function automatic void ref_op(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o,
                                   output logic [7:0] r, output logic il);
        il = 1'b0;
        case (o)
            4'd0: r = ~x;
            4'd1: r = ~y;
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = ~(x & y);
            4'd5: r = ~(x | y);
            4'd6: r = ~x & ~y;
            4'd7: r = ~x | ~y;
            4'd8: r = x ^ y;
            4'd9: r = ~(x ^ y);
            default: begin r = 8'h00; il = 1'b1; end
        endcase
    endfunction

    // One clock: drive inputs, check at negedge, then update the model at the rising edge.
    // Model: capacity 2; a beat accepted at edge N is presented to the consumer in the
    // cycle after edge N+1 and consumed at edge N+2 at the earliest.
    task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [3:0] iop, input logic ordy, output logic acc);
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] r;
        logic       il;
        exp_t       e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op        = iop;
        out_ready = ordy;
        @(negedge clk);
        exp_ir = (q.size() < 2) || ordy;
        exp_ov = (q.size() > 0) && ((cyc - q[0].acc) >= 1);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("result", 32'(result), 32'(q[0].r));
            chk("ones", 32'(ones), 32'(q[0].n));
            chk("illegal", 32'(illegal), 32'(q[0].il));
`ifdef LOGIC_UNIT_DEMORGAN_CHECK_EN
            chk("err", 32'(err), 32'd0);
`endif
        end
        acc = iv && exp_ir;
        @(posedge clk);
        cyc++;
        if (exp_ov && ordy) void'(q.pop_front());
        if (acc) begin
            ref_op(ia, ib, iop, r, il);
            e.r   = r;
            e.n   = 4'($countones(r));
            e.il  = il;
            e.acc = cyc;
            q.push_back(e);
        end
        #1;
    endtask

    initial begin
        logic       acc;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rop;
        int         k;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ones", 32'(ones), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
`ifdef LOGIC_UNIT_DEMORGAN_CHECK_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // All legal ops back-to-back on F0/CC, full throughput.
        for (int i = 0; i < 10; i++) step(1'b1, 8'hF0, 8'hCC, 4'(i), 1'b1, acc);
        repeat (3) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, acc);

        // Illegal opcode followed by a legal one.
        step(1'b1, 8'hFF, 8'hFF, 4'hC, 1'b1, acc);
        step(1'b1, 8'hFF, 8'hFF, 4'd2, 1'b1, acc);
        repeat (3) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, acc);

        // Stall: four beats with the consumer blocked, then released.
        k = 0;
        for (int t = 0; t < 40 && k < 4; t++) begin
            step(1'b1, 8'(8'h11 * (k + 1)), 8'h5A, 4'(k + 2), (t >= 6), acc);
            if (acc) k++;
        end
        chk("stall_all_accepted", 32'(k), 32'd4);
        repeat (4) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, acc);

        // Reset with two beats in flight.
        step(1'b1, 8'hA5, 8'h3C, 4'd8, 1'b0, acc);
        step(1'b1, 8'h0F, 8'hF0, 4'd3, 1'b0, acc);
        rst = 1'b1;
        #2;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_ones", 32'(ones), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        step(1'b1, 8'h81, 8'h18, 4'd3, 1'b1, acc);
        repeat (3) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, acc);

`ifdef LOGIC_UNIT_DEMORGAN_CHECK_EN
        // Dual-form ops on random operands: no mismatch expected.
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 4'($urandom_range(7, 4)), 1'b1, acc);
        end
        repeat (3) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, acc);
        chk("err_count_zero", 32'(err_count), 32'd0);
`endif

        // Random throttling on both sides; a beat is held until accepted.
        ra = 8'($urandom); rb = 8'($urandom); rop = 4'($urandom);
        for (int t = 0; t < 600; t++) begin
            step(($urandom_range(9, 0) < 7), ra, rb, rop, ($urandom_range(9, 0) < 6), acc);
            if (acc) begin
                ra = 8'($urandom); rb = 8'($urandom); rop = 4'($urandom);
            end
        end
        for (int t = 0; t < 10; t++) step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, acc);
        chk("drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
